pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the 5-stage pipeline registers (PC, F/D, D/E, E/M, M/W) and generates their write enables and flushes.
//  Detects load-use hazards, flushes on taken branch, freezes on data-memory wait.
//  Sits beside the datapath; drives the we/flush inputs of every stage register bank.
// PARAMETERS
//  REG_AW           5   register-index width
//  LU_STALL_CYCLES  1   bubble cycles per load-use hazard (legal 1..7; 2 = no MEM->EX forwarding)
//  CNT_W            32  perf-counter width (used only with PIPE_PERF_CNT_EN)
// PORTS
//  clk            in   1       clock, all state on rising edge
//  reset          in   1       asynchronous, active-high
//  id_rs1,id_rs2  in   REG_AW  source regs of instruction in D
//  id_uses_rs1/2  in   1       D instruction actually reads rs1/rs2
//  ex_rd          in   REG_AW  destination reg of instruction in E
//  ex_mem_read    in   1       E instruction is a load
//  ex_branch_taken in  1       branch/jump resolved taken in E
//  dmem_req       in   1       M stage has an active memory access
//  dmem_ready     in   1       data memory completes access this cycle
//  pc_we,fd_we,de_we,em_we,mw_we  out 1  stage register write enables
//  fd_flush,de_flush out  1    load bubble (zeros) into F/D, D/E
//  stall_cycles   out  CNT_W   perf counter (see CONFIGURATION)
//  flush_count    out  CNT_W   perf counter (see CONFIGURATION)
// BEHAVIOUR
//  Outputs combinational from state + inputs; state, stall counter and perf counters registered.
//  reset high: state=RUN, lu_cnt=0, counters=0; all *_we=0, fd_flush=de_flush=1 (async, immediate).
//  lu_hazard = ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
//  mem_stall = dmem_req & ~dmem_ready.
//  States: RUN, LU_STALL, MEM_WAIT. Priority per cycle: mem_stall > branch > lu_hazard.
//  RUN default: all we=1, flushes=0.
//  RUN & mem_stall: all we=0, no flush, ->MEM_WAIT.
//  RUN & branch: all we=1, fd_flush=de_flush=1, stay RUN.
//  RUN & lu_hazard: pc_we=fd_we=0, de_flush=1, em/mw_we=1; LU_STALL_CYCLES==1 -> stay RUN,
//   else ->LU_STALL with lu_cnt=LU_STALL_CYCLES-1.
//  LU_STALL: same outputs as hazard cycle; lu_cnt-- each cycle; lu_cnt==1 -> RUN next.
//   ex_branch_taken and lu_hazard ignored (E holds bubble).
//   mem_stall in LU_STALL: all we=0, no flush, lu_cnt held, stay LU_STALL.
//  MEM_WAIT & ~dmem_ready: all we=0, no flush.
//  MEM_WAIT & dmem_ready: outputs/next state exactly as RUN evaluation (mem_stall=0 this cycle).
//  lu_cnt 3 bits; never wraps (load only from parameter, decrement stops at 1->RUN).
//  Flushes never assert with corresponding we=0 except during reset.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined: stall_cycles += 1 each cycle pc_we==0 (excl. reset);
//   flush_count += 1 each branch-flush cycle; both wrap modulo 2^CNT_W; cleared by reset.
//  Undefined: counters not built, stall_cycles=flush_count=0 constant.
// STRUCTURE
//  pipeline_ctrl_defs.vh: state encodings (RUN=2'd0, LU_STALL=2'd1, MEM_WAIT=2'd2), x0 index constant.
//  Sub-module lu_hazard_detect: combinational lu_hazard compare, parameterised by REG_AW.
//  FSM, lu_cnt and perf counters in top module.
// TESTING
//  Load x5 in E, D reads rs1=x5, LU_STALL_CYCLES=1 -> 1 cycle pc_we=fd_we=0, de_flush=1, then RUN.
//  Same with LU_STALL_CYCLES=3 -> 3 bubble cycles, lu_cnt 2->1, RUN on 4th cycle.
//  Load to x0 with D reading x0 -> no stall, all we=1.
//  ex_branch_taken=1 with lu_hazard=1 -> fd_flush=de_flush=1, pc_we=1, no stall.
//  dmem_req=1, dmem_ready low 4 cycles -> all we=0 4 cycles; ready cycle all we=1; mem_stall in LU_STALL holds lu_cnt.
//  reset pulse mid-LU_STALL -> state RUN, counters 0; with PIPE_PERF_CNT_EN 5 stall + 2 flush -> 5/2.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ============================================================================
// pipeline_hazard_ctrl_pkg : FSM state encodings and shared constants
// Rev 1.0
// ============================================================================
`default_nettype none

package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   localparam int unsigned c_x0_idx   = 0;
   localparam int unsigned c_lu_cnt_w = 3;

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_lu_hazard_detect.sv
// ============================================================================
// pipeline_hazard_ctrl_lu_hazard_detect : load-use hazard compare (E load vs D sources)
// Rev 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl_lu_hazard_detect #(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_uses_rs1,
   input  logic              id_uses_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   output logic              lu_hazard
);
   import pipeline_hazard_ctrl_pkg::*;

   logic w_rd_live;
   logic w_rs1_match;
   logic w_rs2_match;

   // x0 is hardwired zero, so a load targeting it never creates a dependency
   assign w_rd_live   = (ex_rd != REG_AW'(c_x0_idx));
   assign w_rs1_match = id_uses_rs1 & (id_rs1 == ex_rd);
   assign w_rs2_match = id_uses_rs2 & (id_rs2 == ex_rd);
   assign lu_hazard   = ex_mem_read & w_rd_live & (w_rs1_match | w_rs2_match);

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// pipeline_hazard_ctrl : 5-stage pipeline register sequencing (stall/flush/freeze)
// Optional perf counters built when PIPE_PERF_CNT_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
   parameter int REG_AW          = 5,
   parameter int LU_STALL_CYCLES = 1,
   parameter int CNT_W           = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_uses_rs1,
   input  logic              id_uses_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic              ex_branch_taken,
   input  logic              dmem_req,
   input  logic              dmem_ready,
   output logic              pc_we,
   output logic              fd_we,
   output logic              de_we,
   output logic              em_we,
   output logic              mw_we,
   output logic              fd_flush,
   output logic              de_flush,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_count
);
   import pipeline_hazard_ctrl_pkg::*;

   localparam logic [c_lu_cnt_w-1:0] c_lu_load  = c_lu_cnt_w'(LU_STALL_CYCLES - 1);
   localparam bit                    c_multi_lu = (LU_STALL_CYCLES > 1);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [c_lu_cnt_w-1:0]   r_lu_cnt;
   logic [c_lu_cnt_w-1:0]   w_lu_cnt_nxt;
   logic                    w_lu_hazard;
   logic                    w_mem_stall;
   logic                    w_front_we;
   logic                    w_back_we;
   logic                    w_fd_flush;
   logic                    w_de_flush;

   pipeline_hazard_ctrl_lu_hazard_detect #(
      .REG_AW (REG_AW)
   ) u_lu_detect (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .ex_rd       (ex_rd),
      .ex_mem_read (ex_mem_read),
      .lu_hazard   (w_lu_hazard)
   );

   assign w_mem_stall = dmem_req & ~dmem_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= RUN;
         r_lu_cnt <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_lu_cnt <= w_lu_cnt_nxt;
      end
   end

   // front = PC and F/D; back = D/E, E/M, M/W
   always_comb begin
      w_state_nxt  = r_state;
      w_lu_cnt_nxt = r_lu_cnt;
      w_front_we   = 1'b1;
      w_back_we    = 1'b1;
      w_fd_flush   = 1'b0;
      w_de_flush   = 1'b0;
      case (r_state)
         LU_STALL: begin
            // E holds the bubble here, so branch and new hazards are not looked at
            if (w_mem_stall) begin
               w_front_we = 1'b0;
               w_back_we  = 1'b0;
            end else begin
               w_front_we = 1'b0;
               w_de_flush = 1'b1;
               if (r_lu_cnt == c_lu_cnt_w'(1)) begin
                  w_state_nxt  = RUN;
                  w_lu_cnt_nxt = '0;
               end else begin
                  w_lu_cnt_nxt = r_lu_cnt - c_lu_cnt_w'(1);
               end
            end
         end
         default: begin
            // MEM_WAIT with ready falls through to the ordinary RUN evaluation
            if (((r_state == MEM_WAIT) && !dmem_ready) || w_mem_stall) begin
               w_front_we  = 1'b0;
               w_back_we   = 1'b0;
               w_state_nxt = MEM_WAIT;
            end else if (ex_branch_taken) begin
               w_fd_flush  = 1'b1;
               w_de_flush  = 1'b1;
               w_state_nxt = RUN;
            end else if (w_lu_hazard) begin
               w_front_we = 1'b0;
               w_de_flush = 1'b1;
               if (c_multi_lu) begin
                  w_state_nxt  = LU_STALL;
                  w_lu_cnt_nxt = c_lu_load;
               end else begin
                  w_state_nxt = RUN;
               end
            end else begin
               w_state_nxt = RUN;
            end
         end
      endcase
   end

   assign pc_we    = ~reset & w_front_we;
   assign fd_we    = ~reset & w_front_we;
   assign de_we    = ~reset & w_back_we;
   assign em_we    = ~reset & w_back_we;
   assign mw_we    = ~reset & w_back_we;
   assign fd_flush = reset | w_fd_flush;
   assign de_flush = reset | w_de_flush;

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cycles;
   logic [CNT_W-1:0] r_flush_count;

   // fd_flush is only raised by a taken branch outside reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cycles <= '0;
         r_flush_count  <= '0;
      end else begin
         if (!w_front_we) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
         if (w_fd_flush)  r_flush_count  <= r_flush_count + CNT_W'(1);
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_count  = r_flush_count;
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// tb_pipeline_hazard_ctrl : directed checks, LU_STALL_CYCLES=1 and =3 side by side
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

   // {pc_we, fd_we, de_we, em_we, mw_we, fd_flush, de_flush}
   localparam logic [6:0] c_o_run = 7'b11111_00;
   localparam logic [6:0] c_o_stl = 7'b00000_00;
   localparam logic [6:0] c_o_br  = 7'b11111_11;
   localparam logic [6:0] c_o_bub = 7'b00111_01;
   localparam logic [6:0] c_o_rst = 7'b00000_11;
`ifdef PIPE_PERF_CNT_EN
   localparam int c_exp_stall = 5;
   localparam int c_exp_flush = 2;
`else
   localparam int c_exp_stall = 0;
   localparam int c_exp_flush = 0;
`endif

   logic       clk;
   logic       reset;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
   logic       dmem_req, dmem_ready;

   logic        pc_we1, fd_we1, de_we1, em_we1, mw_we1, fd_flush1, de_flush1;
   logic        pc_we3, fd_we3, de_we3, em_we3, mw_we3, fd_flush3, de_flush3;
   logic [31:0] stall1, flush1, stall3, flush3;
   logic [6:0]  o1, o3;

   int n_checks = 0;
   int n_fail   = 0;

   assign o1 = {pc_we1, fd_we1, de_we1, em_we1, mw_we1, fd_flush1, de_flush1};
   assign o3 = {pc_we3, fd_we3, de_we3, em_we3, mw_we3, fd_flush3, de_flush3};

   pipeline_hazard_ctrl #(.REG_AW(5), .LU_STALL_CYCLES(1), .CNT_W(32)) dut1 (
      .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_we(pc_we1), .fd_we(fd_we1), .de_we(de_we1), .em_we(em_we1), .mw_we(mw_we1),
      .fd_flush(fd_flush1), .de_flush(de_flush1),
      .stall_cycles(stall1), .flush_count(flush1)
   );

   pipeline_hazard_ctrl #(.REG_AW(5), .LU_STALL_CYCLES(3), .CNT_W(32)) dut3 (
      .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_we(pc_we3), .fd_we(fd_we3), .de_we(de_we3), .em_we(em_we3), .mw_we(mw_we3),
      .fd_flush(fd_flush3), .de_flush(de_flush3),
      .stall_cycles(stall3), .flush_count(flush3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic probe(input string tag, input logic [6:0] e1, input logic [6:0] e3);
      #2;
      check_eq({tag, "/lu1"}, 64'(o1), 64'(e1));
      check_eq({tag, "/lu3"}, 64'(o3), 64'(e3));
   endtask

   task automatic probe_cnt(input string tag, input int es, input int ef);
      #1;
      check_eq({tag, "/stall1"}, 64'(stall1), 64'(es));
      check_eq({tag, "/flush1"}, 64'(flush1), 64'(ef));
      check_eq({tag, "/stall3"}, 64'(stall3), 64'(es));
      check_eq({tag, "/flush3"}, 64'(flush3), 64'(ef));
   endtask

   task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2);
      ex_mem_read = 1'b1; ex_rd = rd;
      id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
   endtask

   task automatic clr_load;
      ex_mem_read = 1'b0; ex_rd = '0;
      id_rs1 = '0; id_uses_rs1 = 1'b0; id_rs2 = '0; id_uses_rs2 = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      clr_load();
      ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;

      tick();
      probe("reset", c_o_rst, c_o_rst);
      probe_cnt("reset_cnt", 0, 0);
      tick();
      reset = 1'b0;
      probe("idle", c_o_run, c_o_run);

      // load x5 in E, D reads x5; branch during the LU_STALL must be ignored
      tick();
      set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      probe("lu_hit", c_o_bub, c_o_bub);
      tick();
      clr_load();
      ex_branch_taken = 1'b1;
      probe("lu_2nd_br", c_o_br, c_o_bub);
      tick();
      ex_branch_taken = 1'b0;
      probe("lu_3rd", c_o_run, c_o_bub);
      tick();
      probe("lu_done", c_o_run, c_o_run);

      // purely combinational probes in RUN: x0, rs2 match, rs2 unused
      set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
      probe("x0_load", c_o_run, c_o_run);
      set_load(5'd7, 5'd3, 1'b0, 5'd7, 1'b1);
      probe("rs2_hit", c_o_bub, c_o_bub);
      set_load(5'd7, 5'd7, 1'b0, 5'd7, 1'b0);
      probe("no_uses", c_o_run, c_o_run);

      // branch wins over a simultaneous load-use hazard
      tick();
      set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      ex_branch_taken = 1'b1;
      probe("br_over_lu", c_o_br, c_o_br);
      tick();
      clr_load();
      ex_branch_taken = 1'b0;
      probe("after_br", c_o_run, c_o_run);

      // memory wait: four not-ready cycles, then release
      dmem_req = 1'b1; dmem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         probe($sformatf("memwait%0d", i), c_o_stl, c_o_stl);
      end
      tick();
      dmem_ready = 1'b1;
      probe("mem_ready", c_o_run, c_o_run);
      tick();
      dmem_req = 1'b0; dmem_ready = 1'b0;
      probe("mem_after", c_o_run, c_o_run);

      // memory stall inside LU_STALL freezes the bubble count
      tick();
      set_load(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
      probe("lu_mem_hit", c_o_bub, c_o_bub);
      tick();
      clr_load();
      dmem_req = 1'b1; dmem_ready = 1'b0;
      probe("lu_mem_s1", c_o_stl, c_o_stl);
      tick();
      probe("lu_mem_s2", c_o_stl, c_o_stl);
      tick();
      dmem_ready = 1'b1;
      probe("lu_mem_rdy", c_o_run, c_o_bub);
      tick();
      dmem_req = 1'b0; dmem_ready = 1'b0;
      probe("lu_mem_last", c_o_run, c_o_bub);
      tick();
      probe("lu_mem_done", c_o_run, c_o_run);

      // reset pulse in the middle of LU_STALL
      tick();
      set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      probe("rst_lu_hit", c_o_bub, c_o_bub);
      tick();
      clr_load();
      reset = 1'b1;
      probe("rst_mid", c_o_rst, c_o_rst);
      probe_cnt("rst_mid_cnt", 0, 0);
      tick();
      reset = 1'b0;
      probe("rst_release", c_o_run, c_o_run);

      // five stall cycles then two branch flushes for the perf counters
      tick();
      dmem_req = 1'b1; dmem_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 0) probe("perf_stall", c_o_stl, c_o_stl);
         tick();
      end
      dmem_ready = 1'b1;
      probe("perf_rdy", c_o_run, c_o_run);
      tick();
      dmem_req = 1'b0; dmem_ready = 1'b0;
      ex_branch_taken = 1'b1;
      for (int i = 0; i < 2; i++) begin
         probe($sformatf("perf_br%0d", i), c_o_br, c_o_br);
         tick();
      end
      ex_branch_taken = 1'b0;
      probe_cnt("perf_cnt", c_exp_stall, c_exp_flush);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
